// File: rtl/mem_subsys.sv
// mem_subsys: single-port data memory for a small RISC-V style core, with a
// small memory-mapped I/O window next to it.
//
// Parameters:
//   DEPTH      RAM depth in 32-bit words (power of two, 16..4096)
//   MMIO_BASE  256-byte-aligned base address of the MMIO window
//
// Ports:
//   clk         sole clock, rising edge
//   reset       synchronous, active-low reset
//   we          store strobe from the core
//   funct3      access size/sign (lb/lh/lw/lbu/lhu, stores use sb/sh/sw codes)
//   a           byte address
//   wd          store data, right-aligned
//   rd          load data, aligned and sign/zero extended (combinational)
//   misaligned  access is not naturally aligned for its size
//   gpio_out    GPIO register contents
//   done        sticky test-finish flag, set by the first TOHOST store
//   done_code   value written by that TOHOST store
//
// MMIO map (offsets from MMIO_BASE): 0x00 CYCLE (RO), 0x04 TOHOST (WO),
// 0x08 GPIO (RW). Everything else reads 0 and ignores writes.
//
// Build option: define MEM_SUBSYS_CYCLE_CNT_EN to include the free-running
// CYCLE counter. Without it there are no counter flops and offset 0x00
// reads 0.

module mem_subsys #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        misaligned,
    output logic [31:0] gpio_out,
    output logic        done,
    output logic [31:0] done_code
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wordIdx;
    logic [7:0]    mmioOff;
    logic          isMmio;
    logic          isHalf;
    logic          isWord;
    logic [31:0]   cycleCount;
    logic [31:0]   readWord;
    logic [7:0]    loadByte;
    logic [15:0]   loadHalf;
    logic [3:0]    laneMask;
    logic [31:0]   storeData;
    logic          ramWrite;
    logic          mmioWrite;

    // Upper RAM address bits are ignored, so addresses alias modulo DEPTH words.
    assign wordIdx = a[AW+1:2];
    assign mmioOff = a[7:0];
    assign isMmio  = (a[31:8] == MMIO_BASE[31:8]);

    assign isHalf     = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign isWord     = (funct3 == 3'b010);
    assign misaligned = (isHalf && a[0]) || (isWord && (a[1:0] != 2'b00));

    // Only the three store encodings write anything; odd funct3 codes with we
    // set are treated as no-ops rather than guessed at.
    assign ramWrite  = reset && we && !isMmio && !misaligned
                       && ((funct3 == 3'b000) || (funct3 == 3'b001) || isWord);
    assign mmioWrite = reset && we && isMmio && isWord && !misaligned;

`ifdef MEM_SUBSYS_CYCLE_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycleCount <= '0;
        end else begin
            cycleCount <= cycleCount + 32'd1;
        end
    end
`else
    assign cycleCount = '0;
`endif

    // Raw word selection: the array or MMIO register as it stood before the
    // current edge, so a same-cycle store is not forwarded.
    always_comb begin
        readWord = '0;
        if (isMmio) begin
            case (mmioOff)
                8'h00:   readWord = cycleCount;
                8'h08:   readWord = gpio_out;
                default: readWord = '0;
            endcase
        end else begin
            readWord = mem[wordIdx];
        end
    end

    always_comb begin
        loadByte = '0;
        case (a[1:0])
            2'd0: loadByte = readWord[7:0];
            2'd1: loadByte = readWord[15:8];
            2'd2: loadByte = readWord[23:16];
            2'd3: loadByte = readWord[31:24];
            default: loadByte = '0;
        endcase
        loadHalf = a[1] ? readWord[31:16] : readWord[15:0];
    end

    always_comb begin
        rd = '0;
        if (!misaligned) begin
            case (funct3)
                3'b000:  rd = {{24{loadByte[7]}}, loadByte};
                3'b001:  rd = {{16{loadHalf[15]}}, loadHalf};
                3'b100:  rd = {24'd0, loadByte};
                3'b101:  rd = {16'd0, loadHalf};
                default: rd = readWord;
            endcase
        end
    end

    // Store data is replicated across lanes so the lane mask alone decides
    // which bytes land.
    always_comb begin
        laneMask  = 4'b0000;
        storeData = wd;
        case (funct3)
            3'b000: begin
                laneMask  = 4'b0001 << a[1:0];
                storeData = {4{wd[7:0]}};
            end
            3'b001: begin
                laneMask  = a[1] ? 4'b1100 : 4'b0011;
                storeData = {2{wd[15:0]}};
            end
            3'b010: begin
                laneMask  = 4'b1111;
                storeData = wd;
            end
            default: begin
                laneMask  = 4'b0000;
                storeData = wd;
            end
        endcase
    end

    // RAM has no reset; ramWrite already folds in reset so stores during
    // reset are discarded.
    always_ff @(posedge clk) begin
        if (ramWrite) begin
            for (int i = 0; i < 4; i++) begin
                if (laneMask[i]) begin
                    mem[wordIdx][8*i +: 8] <= storeData[8*i +: 8];
                end
            end
        end
    end

    // TOHOST is sticky: once done is set, later TOHOST stores are dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            gpio_out  <= '0;
            done      <= 1'b0;
            done_code <= '0;
        end else if (mmioWrite) begin
            if (mmioOff == 8'h04 && !done) begin
                done      <= 1'b1;
                done_code <= wd;
            end
            if (mmioOff == 8'h08) begin
                gpio_out <= wd;
            end
        end
    end

endmodule

// File: tb/tb_mem_subsys.sv
// tb_mem_subsys: directed self-checking bench for mem_subsys with default
// parameters (DEPTH=64, MMIO_BASE=32'hFFFF_FF00). Expected values are
// hand-computed constants. The CYCLE expectation follows whether
// MEM_SUBSYS_CYCLE_CNT_EN is defined for the build.

module tb_mem_subsys;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;

    localparam logic [2:0] F_LB  = 3'b000;
    localparam logic [2:0] F_LH  = 3'b001;
    localparam logic [2:0] F_LW  = 3'b010;
    localparam logic [2:0] F_LBU = 3'b100;
    localparam logic [2:0] F_LHU = 3'b101;

    logic        clk;
    logic        reset;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        misaligned;
    logic [31:0] gpio_out;
    logic        done;
    logic [31:0] done_code;

    int vectorCount = 0;
    int errorCount  = 0;

    mem_subsys #(
        .DEPTH     (64),
        .MMIO_BASE (BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .funct3     (funct3),
        .a          (a),
        .wd         (wd),
        .rd         (rd),
        .misaligned (misaligned),
        .gpio_out   (gpio_out),
        .done       (done),
        .done_code  (done_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // One store: drive, take one rising edge, then release we.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [2:0] f3);
        we     = 1'b1;
        a      = addr;
        wd     = data;
        funct3 = f3;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic loadCheck(input string tag, input logic [31:0] addr,
                             input logic [2:0] f3, input logic [31:0] expected);
        we     = 1'b0;
        a      = addr;
        funct3 = f3;
        @(negedge clk);
        checkOutput(tag, rd, expected);
    endtask

    initial begin
        reset  = 1'b0;
        we     = 1'b0;
        funct3 = F_LW;
        a      = '0;
        wd     = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_gpio", gpio_out, 32'h0);
        checkOutput("rst_done", {31'd0, done}, 32'h0);
        checkOutput("rst_code", done_code, 32'h0);

        // Ten edges with reset released.
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
`ifdef MEM_SUBSYS_CYCLE_CNT_EN
        loadCheck("cycle10", BASE, F_LW, 32'd10);
        applyStimulus(BASE, 32'h1234_5678, F_LW);
        loadCheck("cycle_wr", BASE, F_LW, 32'd11);
`else
        loadCheck("cycle_off", BASE, F_LW, 32'd0);
        applyStimulus(BASE, 32'h1234_5678, F_LW);
        loadCheck("cycle_off_wr", BASE, F_LW, 32'd0);
`endif

        // Load extraction and extension.
        applyStimulus(32'h10, 32'h8899_AABB, F_LW);
        loadCheck("lb_13",  32'h13, F_LB,  32'hFFFF_FF88);
        loadCheck("lbu_13", 32'h13, F_LBU, 32'h0000_0088);
        loadCheck("lh_12",  32'h12, F_LH,  32'hFFFF_8899);
        loadCheck("lhu_12", 32'h12, F_LHU, 32'h0000_8899);
        loadCheck("lb_10",  32'h10, F_LB,  32'hFFFF_FFBB);
        loadCheck("lhu_10", 32'h10, F_LHU, 32'h0000_AABB);
        loadCheck("lw_10",  32'h10, F_LW,  32'h8899_AABB);
        loadCheck("f3_011", 32'h10, 3'b011, 32'h8899_AABB);

        // Byte and halfword store lanes.
        applyStimulus(32'h20, 32'h0, F_LW);
        applyStimulus(32'h21, 32'hFFFF_FF7F, 3'b000);
        applyStimulus(32'h22, 32'hABCD_1234, 3'b001);
        loadCheck("mask_20", 32'h20, F_LW, 32'h1234_7F00);

        // Misaligned stores are suppressed; misaligned loads return 0.
        applyStimulus(32'h04, 32'h1122_3344, F_LW);
        we = 1'b1; a = 32'h05; wd = 32'hFFFF_FFFF; funct3 = 3'b001;
        #1;
        checkOutput("mis_sh05", {31'd0, misaligned}, 32'h1);
        @(posedge clk); #1;
        a = 32'h06; funct3 = 3'b010;
        #1;
        checkOutput("mis_sw06", {31'd0, misaligned}, 32'h1);
        @(posedge clk); #1;
        we = 1'b0;
        loadCheck("mis_keep", 32'h04, F_LW, 32'h1122_3344);
        checkOutput("mis_clr", {31'd0, misaligned}, 32'h0);
        loadCheck("mis_ld", 32'h06, F_LW, 32'h0);
        loadCheck("mis_lh", 32'h07, F_LHU, 32'h0);

        // Same-cycle load and store: old value now, new value next cycle.
        applyStimulus(32'h40, 32'h1, F_LW);
        we = 1'b1; a = 32'h40; wd = 32'h2; funct3 = F_LW;
        #1;
        checkOutput("rmw_old", rd, 32'h1);
        @(posedge clk); #1;
        we = 1'b0;
        loadCheck("rmw_new", 32'h40, F_LW, 32'h2);

        // Alias wrap: 0x100 maps to word 0 with 64 words.
        applyStimulus(32'h100, 32'h55, F_LW);
        loadCheck("alias", 32'h000, F_LW, 32'h55);

        // GPIO register; sub-word MMIO stores ignored.
        applyStimulus(BASE + 32'h8, 32'h0000_A5A5, F_LW);
        checkOutput("gpio_wr", gpio_out, 32'h0000_A5A5);
        loadCheck("gpio_rd", BASE + 32'h8, F_LW, 32'h0000_A5A5);
        applyStimulus(BASE + 32'h8, 32'h0000_00FF, 3'b000);
        checkOutput("gpio_sb", gpio_out, 32'h0000_A5A5);
        loadCheck("mmio_oth", BASE + 32'h10, F_LW, 32'h0);

        // TOHOST is sticky and reads back 0.
        applyStimulus(BASE + 32'h4, 32'h0000_CAFE, F_LW);
        checkOutput("done_set", {31'd0, done}, 32'h1);
        checkOutput("code_set", done_code, 32'h0000_CAFE);
        applyStimulus(BASE + 32'h4, 32'h0000_BEEF, F_LW);
        checkOutput("code_hold", done_code, 32'h0000_CAFE);
        loadCheck("tohost_rd", BASE + 32'h4, F_LW, 32'h0);

        // Reset beats simultaneous stores; RAM keeps its contents.
        applyStimulus(32'h30, 32'h99, F_LW);
        reset = 1'b0;
        applyStimulus(BASE + 32'h8, 32'h1, F_LW);
        checkOutput("rst_gpio2", gpio_out, 32'h0);
        checkOutput("rst_done2", {31'd0, done}, 32'h0);
        checkOutput("rst_code2", done_code, 32'h0);
        applyStimulus(32'h30, 32'h77, F_LW);
        reset = 1'b1;
        loadCheck("rst_ramwr", 32'h30, F_LW, 32'h99);
        loadCheck("rst_ramkeep", 32'h10, F_LW, 32'h8899_AABB);
`ifdef MEM_SUBSYS_CYCLE_CNT_EN
        loadCheck("cycle_rst", BASE, F_LW, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errorCount);
        $finish;
    end

endmodule
